// File: rtl/decode_pkg.sv
// Shared decode definitions: datapath width default, RV opcodes, ALUOp encodings
// and the control-word decode used by the decode stage.
package decode_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
        logic [3:0] funct4;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] inst);
        ctrl_t c;
        c        = '0;
        c.funct4 = {inst[30], inst[14:12]};
        case (inst[6:0])
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_R;
            end
            OP_I_ALU: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_I;
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_BRANCH: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_BRANCH;
            end
            default: begin
                // Unsupported opcode: every control and funct4 are driven to 0.
                c         = '0;
                c.illegal = 1'b1;
            end
        endcase
        // Writes to x0 are architecturally discarded, so never request them.
        if (inst[11:7] == 5'd0) c.reg_write = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects the immediate format from the opcode
// and sign-extends it to XLEN; formats without an immediate yield 0.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (instruction[6:0])
            OP_I_ALU, OP_LOAD:
                imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            OP_STORE:
                imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// Single-entry decode pipeline register: decodes a fetched RV instruction into
// register specifiers, control signals and immediate with one-cycle latency.
module instruction_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] imm,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            ALUSrc,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic [3:0]      funct4,
    output logic            illegal,
    output logic [31:0]     decode_count
);

    // Handshakes: a word moves when valid && ready on the same rising edge.
    // valid never depends on ready; the stage takes a new word whenever its
    // register is empty or being drained this cycle, unless a flush is active.
    logic            accept;
    ctrl_t           ctrl_d;
    logic [XLEN-1:0] imm_d;

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb ctrl_d = decode_ctrl(instruction);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instruction (instruction),
        .imm         (imm_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            rs1          <= '0;
            rs2          <= '0;
            rd           <= '0;
            out_pc       <= '0;
            imm          <= '0;
            RegWrite     <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            MemtoReg     <= 1'b0;
            ALUSrc       <= 1'b0;
            Branch       <= 1'b0;
            ALUOp        <= '0;
            funct4       <= '0;
            illegal      <= 1'b0;
            decode_count <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rs1       <= instruction[19:15];
            rs2       <= instruction[24:20];
            rd        <= instruction[11:7];
            out_pc    <= pc;
            imm       <= imm_d;
            RegWrite  <= ctrl_d.reg_write;
            MemRead   <= ctrl_d.mem_read;
            MemWrite  <= ctrl_d.mem_write;
            MemtoReg  <= ctrl_d.mem_to_reg;
            ALUSrc    <= ctrl_d.alu_src;
            Branch    <= ctrl_d.branch;
            ALUOp     <= ctrl_d.alu_op;
            funct4    <= ctrl_d.funct4;
            illegal   <= ctrl_d.illegal;
            if (!ctrl_d.illegal) decode_count <= decode_count + 32'd1;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed vector table, hand-written
// handshake/flush/reset sequences, then random traffic against a reference model.
module tb_instruction_decode_stage;

    localparam int XLEN  = 64;
    localparam int OUT_W = 15 + 2*XLEN + 6 + 2 + 4 + 1;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] out_pc, imm;
    logic            RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch;
    logic [1:0]      ALUOp;
    logic [3:0]      funct4;
    logic            illegal;
    logic [31:0]     decode_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic             m_valid;
    logic [OUT_W-1:0] m_out;
    logic [31:0]      m_count;

    instruction_decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .out_pc(out_pc), .imm(imm),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .Branch(Branch),
        .ALUOp(ALUOp), .funct4(funct4), .illegal(illegal),
        .decode_count(decode_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] p,
                         input logic ordy, input logic fl);
        in_valid    = v;
        instruction = inst;
        pc          = p;
        out_ready   = ordy;
        flush       = fl;
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] dut_vec();
        return {rs1, rs2, rd, out_pc, imm, RegWrite, MemRead, MemWrite, MemtoReg,
                ALUSrc, Branch, ALUOp, funct4, illegal};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [OUT_W-1:0] ref_decode(input logic [31:0] inst, input logic [XLEN-1:0] p);
        logic rw, mr, mw, mtr, as, br, ill;
        logic [1:0]        aop;
        logic [3:0]        f4;
        logic [XLEN-1:0]   im;
        logic signed [11:0] i12, s12;
        logic signed [12:0] b13;
        i12 = inst[31:20];
        s12 = {inst[31:25], inst[11:7]};
        b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        {rw, mr, mw, mtr, as, br, ill} = '0;
        aop = 2'd0;
        im  = '0;
        f4  = {inst[30], inst[14:12]};
        case (inst[6:0])
            7'h33: begin rw = 1; aop = 2'd2; end
            7'h13: begin rw = 1; as = 1; aop = 2'd3; im = 64'(i12); end
            7'h03: begin rw = 1; mr = 1; mtr = 1; as = 1; im = 64'(i12); end
            7'h23: begin mw = 1; as = 1; im = 64'(s12); end
            7'h63: begin br = 1; aop = 2'd1; im = 64'(b13); end
            default: begin ill = 1; f4 = 4'd0; end
        endcase
        if (inst[11:7] == 5'd0) rw = 0;
        return {inst[19:15], inst[24:20], inst[11:7], p, im, rw, mr, mw, mtr, as, br, aop, f4, ill};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: op = 7'h33;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4: op = 7'h63;
            default: op = r[6:0];
        endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return {r[31:7], op};
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] imm;
        logic [5:0]      ctl;   // RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch
        logic [1:0]      aop;
        logic [3:0]      f4;
        logic            ill;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [OUT_W-1:0] vec_exp(input vec_t v, input logic [XLEN-1:0] p);
        return {v.rs1, v.rs2, v.rd, p, v.imm, v.ctl, v.aop, v.f4, v.ill};
    endfunction

    initial begin
        logic [31:0] exp_count;
        logic [OUT_W-1:0] held;
        logic [OUT_W-1:0] got;

        vecs[0] = '{32'h002081B3, 64'h100, 5'd1,  5'd2,  5'd3,  64'h0,                 6'b100000, 2'b10, 4'h0, 1'b0};
        vecs[1] = '{32'hFF813283, 64'h104, 5'd2,  5'd24, 5'd5,  64'hFFFFFFFFFFFFFFF8, 6'b110110, 2'b00, 4'hB, 1'b0};
        vecs[2] = '{32'hFE208EE3, 64'h108, 5'd1,  5'd2,  5'd29, 64'hFFFFFFFFFFFFFFFC, 6'b000001, 2'b01, 4'h8, 1'b0};
        vecs[3] = '{32'h00713823, 64'h10C, 5'd2,  5'd7,  5'd16, 64'h10,                6'b001010, 2'b00, 4'h3, 1'b0};
        vecs[4] = '{32'h00000013, 64'h110, 5'd0,  5'd0,  5'd0,  64'h0,                 6'b000010, 2'b11, 4'h0, 1'b0};
        vecs[5] = '{32'hFFF00093, 64'h114, 5'd0,  5'd31, 5'd1,  64'hFFFFFFFFFFFFFFFF, 6'b100010, 2'b11, 4'h8, 1'b0};
        vecs[6] = '{32'h0000007F, 64'h118, 5'd0,  5'd0,  5'd0,  64'h0,                 6'b000000, 2'b00, 4'h0, 1'b1};
        vecs[7] = '{32'h40C58533, 64'h11C, 5'd11, 5'd12, 5'd10, 64'h0,                 6'b100000, 2'b10, 4'h8, 1'b0};

        // Reset state
        reset = 1'b0;
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        repeat (2) step();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_payload", dut_vec(), '0);
        check("reset_count", decode_count, 32'd0);
        #2 reset = 1'b1;
        step();
        check("idle_in_ready", in_ready, 1'b1);

        // Table-driven decode, one word per cycle with the consumer always ready
        exp_count = 32'd0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].pc, 1'b1, 1'b0);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            step();
            if (!vecs[i].ill) exp_count++;
            check($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_payload", i), dut_vec(), vec_exp(vecs[i], vecs[i].pc));
            check($sformatf("vec%0d_count", i), decode_count, exp_count);
        end

        // Backpressure: output held, no acceptance for 3 cycles
        held = vec_exp(vecs[7], vecs[7].pc);
        drive(1'b1, vecs[0].inst, 64'h200, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
            step();
            check($sformatf("stall%0d_out_valid", c), out_valid, 1'b1);
            check($sformatf("stall%0d_payload", c), dut_vec(), held);
            check($sformatf("stall%0d_count", c), decode_count, exp_count);
        end
        drive(1'b1, vecs[0].inst, 64'h200, 1'b1, 1'b0);
        check("release_in_ready", in_ready, 1'b1);
        step();
        exp_count++;
        check("release_payload", dut_vec(), vec_exp(vecs[0], 64'h200));
        check("release_count", decode_count, exp_count);

        // Flush kills the held word, blocks acceptance, count unchanged
        drive(1'b1, vecs[1].inst, 64'h204, 1'b0, 1'b1);
        check("flush_in_ready", in_ready, 1'b0);
        step();
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_count", decode_count, exp_count);
        check("flush_payload_held", dut_vec(), vec_exp(vecs[0], 64'h200));

        // Illegal opcode: accepted, flagged, not counted
        drive(1'b1, 32'h0000007F, 64'h300, 1'b1, 1'b0);
        step();
        check("illegal_out_valid", out_valid, 1'b1);
        check("illegal_payload", dut_vec(), vec_exp(vecs[6], 64'h300));
        check("illegal_count", decode_count, exp_count);

        // Asynchronous reset mid-stream
        drive(1'b1, vecs[0].inst, 64'h400, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_payload", dut_vec(), '0);
        check("async_rst_count", decode_count, 32'd0);
        step();
        check("rst_hold_payload", dut_vec(), '0);
        #2 reset = 1'b1;
        drive(1'b1, vecs[0].inst, 64'h400, 1'b1, 1'b0);
        step();
        check("post_rst_out_valid", out_valid, 1'b1);
        check("post_rst_payload", dut_vec(), vec_exp(vecs[0], 64'h400));
        check("post_rst_count", decode_count, 32'd1);

        // Random traffic against the reference model, starting from reset
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        #2 reset = 1'b1;
        step();
        m_valid = 1'b0;
        m_out   = '0;
        m_count = 32'd0;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            logic exp_ready;
            drive($urandom_range(0, 99) < 70, rand_inst(), {$urandom(), $urandom()},
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 8);
            exp_ready = (!m_valid || out_ready) && !flush;
            check("rnd_in_ready", in_ready, exp_ready);
            // Scoreboard: the consumer takes the front word on a handshake
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rnd_sb_underflow: got handshake expected none at cycle %0d", c);
                end else begin
                    got = exp_q.pop_front();
                    check("rnd_sb_word", dut_vec(), got);
                end
            end else if (flush) begin
                exp_q.delete();
            end
            if (in_valid && exp_ready) begin
                m_out   = ref_decode(instruction, pc);
                m_valid = 1'b1;
                if (!m_out[0]) m_count = m_count + 32'd1;
                exp_q.push_back(m_out);
            end else if (flush || (m_valid && out_ready)) begin
                m_valid = 1'b0;
            end
            step();
            check("rnd_out_valid", out_valid, m_valid);
            check("rnd_payload", dut_vec(), m_out);
            check("rnd_count", decode_count, m_count);
        end

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 Parameter XLEN, default 64: datapath width of pc, imm and out_pc.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1 and in_ready  out  1: fetch-side handshake.
REQ-005 instruction  in  32 and pc  in  XLEN: fetched word and its address.
REQ-006 flush  in  1: synchronous kill of the held instruction.
REQ-007 out_valid  out  1 and out_ready  in  1: register-file-side handshake.
REQ-008 rs1, rs2, rd  out  5 each: register specifiers for the register file.
REQ-009 out_pc  out  XLEN and imm  out  XLEN: registered pc and sign-extended immediate.
REQ-010 RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch  out  1 each; ALUOp  out  2; funct4  out  4 ({instruction[30], instruction[14:12]}).
REQ-011 illegal  out  1: unsupported opcode; decode_count  out  32: legal instructions accepted.

Function
REQ-012 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-013 Accept = in_valid && in_ready; on accept, all outputs SHALL load the decode of instruction at the next edge and out_valid SHALL be 1 (one-cycle latency).
REQ-014 Without accept, out_valid SHALL clear after out_valid && out_ready and otherwise hold; payload outputs SHALL hold.
REQ-015 flush SHALL clear out_valid at the next edge, block acceptance that cycle, and leave decode_count unchanged.
REQ-016 R-type (0110011): RegWrite=1, ALUSrc=0, ALUOp=10, imm=0.
REQ-017 I-ALU (0010011): RegWrite=1, ALUSrc=1, ALUOp=11, imm=sext(inst[31:20]).
REQ-018 Load (0000011): RegWrite=1, MemRead=1, MemtoReg=1, ALUSrc=1, ALUOp=00, imm=sext(inst[31:20]).
REQ-019 Store (0100011): MemWrite=1, ALUSrc=1, ALUOp=00, imm=sext({inst[31:25],inst[11:7]}).
REQ-020 Branch (1100011): Branch=1, ALUOp=01, imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
REQ-021 Controls not listed for an opcode SHALL be 0.
REQ-022 Any other opcode SHALL set illegal=1 with all controls 0 and imm=0; rs1/rs2/rd SHALL still carry the instruction fields.
REQ-023 RegWrite SHALL be forced to 0 when rd==0.
REQ-024 decode_count SHALL increment by 1 per accepted legal instruction and wrap from 0xFFFFFFFF to 0.

Reset
REQ-025 While reset is low, every output register SHALL be 0 (out_valid=0, decode_count=0), asynchronously.
REQ-026 Reset assertion mid-transfer SHALL discard the held instruction; the first accept after release SHALL behave as from power-up.

Structure
REQ-027 Package decode_pkg SHALL hold the opcode constants, ALUOp encodings and the XLEN default.
REQ-028 The immediate generator SHALL be a combinational sub-module imm_gen.

Verification
REQ-029 0x002081B3 (add x3,x1,x2), pc=0x100, out_ready=1 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, RegWrite=1, ALUOp=10, out_pc=0x100, decode_count=1.
REQ-030 0xFF813283 (ld x5,-8(x2)) -> imm=0xFFFFFFFFFFFFFFF8, MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1.
REQ-031 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFFFFFFFFFC, Branch=1, ALUOp=01, RegWrite=0.
REQ-032 out_valid=1, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> new word loads next cycle.
REQ-033 flush=1 with in_valid=1, out_valid=1 -> out_valid=0 next cycle and decode_count unchanged; 0x0000007F -> illegal=1, controls 0, count unchanged.
REQ-034 reset low mid-stream -> all outputs 0 immediately; after release, one accept -> decode_count=1.
